// File: rtl/rgb2gray_pkg.sv
// Shared definitions for the RGB-to-grayscale converter: conversion modes
// and the per-mode channel weights (each set sums to 1 << WEIGHT_SHIFT).
package rgb2gray_pkg;

    typedef enum logic [1:0] {
        MODE_LUMA  = 2'd0,
        MODE_AVG   = 2'd1,
        MODE_GREEN = 2'd2,
        MODE_MAX   = 2'd3
    } mode_e;

    localparam int WEIGHT_SHIFT = 8;

    typedef struct packed {
        logic [8:0] wr;
        logic [8:0] wg;
        logic [8:0] wb;
    } weights_t;

    localparam weights_t W_LUMA  = '{wr: 9'd77, wg: 9'd150, wb: 9'd29};
    localparam weights_t W_AVG   = '{wr: 9'd85, wg: 9'd86,  wb: 9'd85};
    localparam weights_t W_GREEN = '{wr: 9'd0,  wg: 9'd256, wb: 9'd0};

    // MODE_MAX bypasses the weights, so it falls back to the luma set here.
    function automatic weights_t weightsFor(input mode_e m);
        weights_t w;
        case (m)
            MODE_AVG:   w = W_AVG;
            MODE_GREEN: w = W_GREEN;
            default:    w = W_LUMA;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/gray_frame_stats.sv
// Per-frame gray statistics (min, max, saturating sum and count), aligned to
// the pipeline output by delaying frame-valid three cycles.
module gray_frame_stats
    import rgb2gray_pkg::*;
#(
    parameter int OUT_W = 8,
    parameter int ACC_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fval_i,
    input  logic             dval_i,
    input  logic [OUT_W-1:0] gray_i,
    output logic             done_o,
    output logic [OUT_W-1:0] min_o,
    output logic [OUT_W-1:0] max_o,
    output logic [ACC_W-1:0] sum_o,
    output logic [ACC_W-1:0] count_o
);

    logic             fv1_q, fv2_q, fv3_q;
    logic [OUT_W-1:0] accMin_q, accMin_d;
    logic [OUT_W-1:0] accMax_q, accMax_d;
    logic [ACC_W-1:0] accSum_q, accSum_d;
    logic [ACC_W-1:0] accCnt_q, accCnt_d;
    logic [OUT_W-1:0] outMin_q, outMin_d;
    logic [OUT_W-1:0] outMax_q, outMax_d;
    logic [ACC_W-1:0] outSum_q, outSum_d;
    logic [ACC_W-1:0] outCnt_q, outCnt_d;
    logic             done_q, done_d;
    logic [ACC_W:0]   sumWide;
    logic             frameStart, frameEnd, countPix;

    // Edges are detected one cycle early from fv2 so the clear and publish
    // land on the same clock edge where fv3 itself changes.
    assign frameStart = fv2_q & ~fv3_q;
    assign frameEnd   = fv3_q & ~fv2_q;
    assign countPix   = fv3_q & dval_i;
    assign sumWide    = {1'b0, accSum_q} + (ACC_W + 1)'(gray_i);

    always_comb begin
        accMin_d = accMin_q;
        accMax_d = accMax_q;
        accSum_d = accSum_q;
        accCnt_d = accCnt_q;
        outMin_d = outMin_q;
        outMax_d = outMax_q;
        outSum_d = outSum_q;
        outCnt_d = outCnt_q;
        done_d   = 1'b0;

        if (countPix) begin
            if (gray_i < accMin_q) accMin_d = gray_i;
            if (gray_i > accMax_q) accMax_d = gray_i;
            accSum_d = sumWide[ACC_W] ? '1 : sumWide[ACC_W-1:0];
            if (accCnt_q != '1) accCnt_d = accCnt_q + ACC_W'(1);
        end

        if (frameStart) begin
            accMin_d = '1;
            accMax_d = '0;
            accSum_d = '0;
            accCnt_d = '0;
        end

        // Publish including the pixel being accumulated on this same edge.
        if (frameEnd) begin
            done_d = 1'b1;
            if (accCnt_d == '0) begin
                outMin_d = '0;
                outMax_d = '0;
                outSum_d = '0;
                outCnt_d = '0;
            end else begin
                outMin_d = accMin_d;
                outMax_d = accMax_d;
                outSum_d = accSum_d;
                outCnt_d = accCnt_d;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fv1_q    <= 1'b0;
            fv2_q    <= 1'b0;
            fv3_q    <= 1'b0;
            accMin_q <= '0;
            accMax_q <= '0;
            accSum_q <= '0;
            accCnt_q <= '0;
            outMin_q <= '0;
            outMax_q <= '0;
            outSum_q <= '0;
            outCnt_q <= '0;
            done_q   <= 1'b0;
        end else begin
            fv1_q    <= fval_i;
            fv2_q    <= fv1_q;
            fv3_q    <= fv2_q;
            accMin_q <= accMin_d;
            accMax_q <= accMax_d;
            accSum_q <= accSum_d;
            accCnt_q <= accCnt_d;
            outMin_q <= outMin_d;
            outMax_q <= outMax_d;
            outSum_q <= outSum_d;
            outCnt_q <= outCnt_d;
            done_q   <= done_d;
        end
    end

    assign done_o  = done_q;
    assign min_o   = outMin_q;
    assign max_o   = outMax_q;
    assign sum_o   = outSum_q;
    assign count_o = outCnt_q;

endmodule

// File: rtl/rgb2gray_pipe.sv
// Three-stage RGB-to-gray converter with a per-frame mode latch; valid and
// coordinates travel alongside the data, statistics hang off the output.
module rgb2gray_pipe
    import rgb2gray_pkg::*;
#(
    parameter int IN_W    = 12,
    parameter int OUT_W   = 8,
    parameter int COORD_W = 16,
    parameter int ACC_W   = 32
) (
    input  logic               iCLK,
    input  logic               iReset,
    input  logic [IN_W-1:0]    iRed,
    input  logic [IN_W-1:0]    iGreen,
    input  logic [IN_W-1:0]    iBlue,
    input  logic               iDval,
    input  logic               iFval,
    input  logic [COORD_W-1:0] iX_Cont,
    input  logic [COORD_W-1:0] iY_Cont,
    input  logic [1:0]         iMode,
    output logic [OUT_W-1:0]   oGray,
    output logic               oDval,
    output logic [COORD_W-1:0] oX_Cont,
    output logic [COORD_W-1:0] oY_Cont,
    output logic               oFrameDone,
    output logic [OUT_W-1:0]   oMin,
    output logic [OUT_W-1:0]   oMax,
    output logic [ACC_W-1:0]   oSum,
    output logic [ACC_W-1:0]   oCount
);

    localparam int PW  = IN_W + 9;
    localparam int RSH = (IN_W > OUT_W) ? (IN_W - OUT_W - 1) : 0;
    localparam logic [IN_W:0] ROUND = (IN_W > OUT_W) ? ((IN_W + 1)'(1) << RSH) : '0;

    logic               fvalPrev_q;
    mode_e              mode_q, mode_d, modeUse;
    weights_t           w;
    logic [IN_W-1:0]    maxC;

    logic               v1_q, v2_q, v3_q;
    logic [PW-1:0]      pr_q, pg_q, pb_q, pr_d, pg_d, pb_d;
    logic [PW-1:0]      prodSum;
    logic [IN_W-1:0]    s2_q, s2_d;
    logic [IN_W:0]      rounded;
    logic [OUT_W-1:0]   gray_q, gray_d;
    logic [COORD_W-1:0] x1_q, y1_q, x2_q, y2_q, x3_q, y3_q;

    // The pixel on the frame's first cycle already uses the newly requested mode.
    always_comb begin
        mode_d  = mode_q;
        modeUse = mode_q;
        if (iFval && !fvalPrev_q) begin
            mode_d  = mode_e'(iMode);
            modeUse = mode_e'(iMode);
        end
    end

    always_comb begin
        w    = weightsFor(modeUse);
        maxC = iRed;
        if (iGreen > maxC) maxC = iGreen;
        if (iBlue > maxC) maxC = iBlue;
        if (modeUse == MODE_MAX) begin
            pr_d = PW'(maxC) << WEIGHT_SHIFT;
            pg_d = '0;
            pb_d = '0;
        end else begin
            pr_d = PW'(iRed) * PW'(w.wr);
            pg_d = PW'(iGreen) * PW'(w.wg);
            pb_d = PW'(iBlue) * PW'(w.wb);
        end
    end

    // Weights sum to 256, so the product sum never exceeds PW bits.
    always_comb begin
        prodSum = pr_q + pg_q + pb_q;
        s2_d    = IN_W'(prodSum >> WEIGHT_SHIFT);
        rounded = {1'b0, s2_q} + ROUND;
        gray_d  = rounded[IN_W] ? '1 : OUT_W'(rounded >> (IN_W - OUT_W));
    end

    always_ff @(posedge iCLK or posedge iReset) begin
        if (iReset) begin
            fvalPrev_q <= 1'b0;
            mode_q     <= MODE_LUMA;
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
            v3_q       <= 1'b0;
            pr_q       <= '0;
            pg_q       <= '0;
            pb_q       <= '0;
            s2_q       <= '0;
            gray_q     <= '0;
            x1_q       <= '0;
            y1_q       <= '0;
            x2_q       <= '0;
            y2_q       <= '0;
            x3_q       <= '0;
            y3_q       <= '0;
        end else begin
            fvalPrev_q <= iFval;
            mode_q     <= mode_d;
            v1_q       <= iDval;
            v2_q       <= v1_q;
            v3_q       <= v2_q;
            if (iDval) begin
                pr_q <= pr_d;
                pg_q <= pg_d;
                pb_q <= pb_d;
                x1_q <= iX_Cont;
                y1_q <= iY_Cont;
            end
            if (v1_q) begin
                s2_q <= s2_d;
                x2_q <= x1_q;
                y2_q <= y1_q;
            end
            if (v2_q) begin
                gray_q <= gray_d;
                x3_q   <= x2_q;
                y3_q   <= y2_q;
            end
        end
    end

    assign oGray   = gray_q;
    assign oDval   = v3_q;
    assign oX_Cont = x3_q;
    assign oY_Cont = y3_q;

    gray_frame_stats #(
        .OUT_W(OUT_W),
        .ACC_W(ACC_W)
    ) u_stats (
        .clk     (iCLK),
        .rst     (iReset),
        .fval_i  (iFval),
        .dval_i  (v3_q),
        .gray_i  (gray_q),
        .done_o  (oFrameDone),
        .min_o   (oMin),
        .max_o   (oMax),
        .sum_o   (oSum),
        .count_o (oCount)
    );

endmodule

// File: tb/tb_rgb2gray_pipe.sv
// Scoreboard bench for rgb2gray_pipe: a reference model predicts pixels and
// frame statistics, a monitor compares them as the DUT presents them.
module tb_rgb2gray_pipe;

    localparam int IN_W    = 12;
    localparam int OUT_W   = 8;
    localparam int COORD_W = 16;
    localparam int ACC_W   = 32;

    logic               iCLK = 1'b0;
    logic               iReset = 1'b0;
    logic [IN_W-1:0]    iRed = '0, iGreen = '0, iBlue = '0;
    logic               iDval = 1'b0, iFval = 1'b0;
    logic [COORD_W-1:0] iX_Cont = '0, iY_Cont = '0;
    logic [1:0]         iMode = '0;
    logic [OUT_W-1:0]   oGray, oMin, oMax;
    logic               oDval, oFrameDone;
    logic [COORD_W-1:0] oX_Cont, oY_Cont;
    logic [ACC_W-1:0]   oSum, oCount;

    rgb2gray_pipe #(
        .IN_W(IN_W), .OUT_W(OUT_W), .COORD_W(COORD_W), .ACC_W(ACC_W)
    ) dut (
        .iCLK(iCLK), .iReset(iReset), .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue),
        .iDval(iDval), .iFval(iFval), .iX_Cont(iX_Cont), .iY_Cont(iY_Cont),
        .iMode(iMode), .oGray(oGray), .oDval(oDval), .oX_Cont(oX_Cont),
        .oY_Cont(oY_Cont), .oFrameDone(oFrameDone), .oMin(oMin), .oMax(oMax),
        .oSum(oSum), .oCount(oCount)
    );

    always #5 iCLK = ~iCLK;

    typedef struct { int gray; int x; int y; int cyc; } pix_t;
    typedef struct { longint mn; longint mx; longint sum; longint cnt; int cyc; } frm_t;

    pix_t pixQ[$];
    frm_t frmQ[$];
    int   frameList[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   lastGray = 0;
    bit   prevFval = 0;
    int   tbMode = 0;
    bit   monActive = 0;

    always @(posedge iCLK) cyc <= cyc + 1;

    // Gray value straight from the conversion rules: weighted sum / 256,
    // then round half-up to 8 bits and clamp.
    function automatic int refGray(input int mode, input int r, input int g, input int b);
        int v;
        case (mode)
            0: v = (77 * r + 150 * g + 29 * b) / 256;
            1: v = (85 * r + 86 * g + 85 * b) / 256;
            2: v = g;
            default: begin
                v = r;
                if (g > v) v = g;
                if (b > v) v = b;
            end
        endcase
        v = (v + 8) / 16;
        if (v > 255) v = 255;
        return v;
    endfunction

    function automatic int randChan();
        case ($urandom_range(0, 7))
            0: return 0;
            1: return 4095;
            default: return int'($urandom_range(0, 4095));
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: actual=%0h required=%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic reportMissing(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s: actual=absent required=present (cycle %0d)", name, cyc);
    endtask

    // Drives one input cycle and updates the reference model for it.
    task automatic applyStimulus(input bit fv, input bit dv, input int r, input int g, input int b,
                                 input int x, input int y, input int mode);
        bit   rise;
        int   useMode;
        int   gv;
        pix_t p;
        frm_t f;
        @(negedge iCLK);
        iFval   = fv;
        iDval   = dv;
        iRed    = r[IN_W-1:0];
        iGreen  = g[IN_W-1:0];
        iBlue   = b[IN_W-1:0];
        iX_Cont = x[COORD_W-1:0];
        iY_Cont = y[COORD_W-1:0];
        iMode   = mode[1:0];
        rise    = fv && !prevFval;
        if (rise) begin
            tbMode = mode;
            frameList.delete();
        end
        useMode = tbMode;
        gv = refGray(useMode, r, g, b);
        if (dv) begin
            p.gray = gv; p.x = x; p.y = y; p.cyc = cyc + 3;
            pixQ.push_back(p);
            if (fv) frameList.push_back(gv);
        end
        if (!fv && prevFval) begin
            f.mn = 0; f.mx = 0; f.sum = 0; f.cnt = frameList.size(); f.cyc = cyc + 3;
            if (frameList.size() > 0) begin
                f.mn = 255;
                foreach (frameList[i]) begin
                    if (frameList[i] < f.mn) f.mn = frameList[i];
                    if (frameList[i] > f.mx) f.mx = frameList[i];
                    f.sum += frameList[i];
                end
                if (f.sum > 64'hFFFF_FFFF) f.sum = 64'hFFFF_FFFF;
            end
            frmQ.push_back(f);
        end
        prevFval = fv;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic doReset();
        @(negedge iCLK);
        iReset = 1'b1;
        iFval = 1'b0;
        iDval = 1'b0;
        pixQ.delete();
        frmQ.delete();
        frameList.delete();
        prevFval = 0;
        tbMode = 0;
        lastGray = 0;
        #1;
        checkOutput("resetGray", oGray, 0);
        checkOutput("resetDval", oDval, 0);
        checkOutput("resetX", oX_Cont, 0);
        checkOutput("resetY", oY_Cont, 0);
        checkOutput("resetDone", oFrameDone, 0);
        checkOutput("resetMin", oMin, 0);
        checkOutput("resetMax", oMax, 0);
        checkOutput("resetSum", oSum, 0);
        checkOutput("resetCount", oCount, 0);
        monActive = 1;
        repeat (2) @(negedge iCLK);
        iReset = 1'b0;
    endtask

    // Monitor: pops expected pixels and frame results when the DUT shows them.
    always @(posedge iCLK) begin
        #1;
        if (monActive) begin
            while (pixQ.size() > 0 && pixQ[0].cyc < cyc) begin
                reportMissing("pixelOut");
                void'(pixQ.pop_front());
            end
            while (frmQ.size() > 0 && frmQ[0].cyc < cyc) begin
                reportMissing("frameDone");
                void'(frmQ.pop_front());
            end
            if (oDval) begin
                if (pixQ.size() == 0) begin
                    reportMissing("expectedPixel");
                end else begin
                    pix_t e;
                    e = pixQ.pop_front();
                    checkOutput("gray", oGray, e.gray);
                    checkOutput("xCont", oX_Cont, e.x);
                    checkOutput("yCont", oY_Cont, e.y);
                    checkOutput("pixelLatency", cyc, e.cyc);
                    lastGray = e.gray;
                end
            end else begin
                checkOutput("grayHold", oGray, lastGray);
            end
            if (oFrameDone) begin
                if (frmQ.size() == 0) begin
                    reportMissing("expectedFrame");
                end else begin
                    frm_t e;
                    e = frmQ.pop_front();
                    checkOutput("frameMin", oMin, e.mn);
                    checkOutput("frameMax", oMax, e.mx);
                    checkOutput("frameSum", oSum, e.sum);
                    checkOutput("frameCount", oCount, e.cnt);
                    checkOutput("frameDoneCycle", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        doReset();

        // Single pulsed pixel, full-scale luma, coordinates 5/7.
        applyStimulus(1, 1, 'hFF0, 'hFF0, 'hFF0, 5, 7, 0);
        idle(6);

        // Luma: red only, then all channels saturating.
        applyStimulus(1, 1, 'hFFF, 0, 0, 1, 1, 0);
        applyStimulus(1, 1, 'hFFF, 'hFFF, 'hFFF, 2, 1, 0);
        idle(5);

        // Max frame, then back-to-back green frame.
        applyStimulus(1, 1, 'h100, 'h800, 'h300, 0, 2, 3);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 'h7F7, 0, 0, 3, 2);
        idle(5);

        // Mode request changes mid-frame; only the next frame picks it up.
        applyStimulus(1, 1, 'h100, 'h800, 'h300, 0, 4, 0);
        applyStimulus(1, 1, 'h100, 'h800, 'h300, 1, 4, 3);
        applyStimulus(1, 1, 'h100, 'h800, 'h300, 2, 4, 3);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 3);
        applyStimulus(1, 1, 'h100, 'h800, 'h300, 0, 5, 3);
        applyStimulus(1, 1, 'h100, 'h800, 'h300, 1, 5, 0);
        idle(5);

        // Four-pixel green frame with gaps: 0x10, 0x80, 0x05, 0xF0.
        applyStimulus(1, 1, 0, 'h100, 0, 0, 6, 2);
        applyStimulus(1, 0, 0, 0, 0, 0, 6, 2);
        applyStimulus(1, 1, 0, 'h800, 0, 1, 6, 2);
        applyStimulus(1, 1, 0, 'h050, 0, 2, 6, 2);
        applyStimulus(1, 0, 0, 0, 0, 0, 6, 2);
        applyStimulus(1, 0, 0, 0, 0, 0, 6, 2);
        applyStimulus(1, 1, 0, 'hF00, 0, 3, 6, 2);
        idle(6);

        // Empty frame and a one-cycle frame.
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
        applyStimulus(1, 1, 'h321, 'h654, 'h987, 9, 9, 1);
        idle(6);

        // Reset in the middle of a frame, then a fresh one-pixel frame.
        applyStimulus(1, 1, 'hABC, 'hDEF, 'h123, 0, 8, 0);
        applyStimulus(1, 1, 'h456, 'h789, 'hABC, 1, 8, 0);
        doReset();
        applyStimulus(1, 1, 'h123, 'h456, 'h789, 0, 9, 1);
        idle(6);

        // Randomised frames, gaps, modes and stray out-of-frame pixels.
        for (int f = 0; f < 40; f++) begin
            int  len;
            int  gap;
            bit  empty;
            len   = $urandom_range(1, 12);
            gap   = $urandom_range(1, 4);
            empty = ($urandom_range(0, 5) == 0);
            for (int i = 0; i < len; i++)
                applyStimulus(1, !empty && ($urandom_range(0, 3) != 0), randChan(), randChan(),
                              randChan(), i, f, $urandom_range(0, 3));
            for (int j = 0; j < gap; j++)
                applyStimulus(0, $urandom_range(0, 3) == 0, randChan(), randChan(), randChan(),
                              100 + j, f, $urandom_range(0, 3));
        end

        idle(10);
        checkOutput("pixelQueueDrained", pixQ.size(), 0);
        checkOutput("frameQueueDrained", frmQ.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
